pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Consumes register indices and control flags decoded in ID, plus EX/MEM/WB pipeline-register state and memory ready handshakes.
- Drives per-stage stall/bubble enables, the PC source select and the EX operand forwarding selects.
- Owns the trap sequencer for syscall_op/break_op: drains older instructions, then redirects to the trap vector.

Parameters:
DRAIN_CYCLES, 3, non-stalled cycles needed to retire instructions older than the trapping one (EX, MEM, WB).
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
clk  input  1  core clock
rstn  input  1  asynchronous active-low reset
id_rs1  input  5  ID source register 1
id_rs2  input  5  ID source register 2 (shamt for immediate shifts, so qualified by use flag)
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_syscall_op  input  1  ID holds ecall
id_break_op  input  1  ID holds ebreak
ex_rd  input  5  EX destination
ex_reg_write  input  1  EX writes rd
ex_mem_read  input  1  EX is a load
ex_redirect  input  1  EX taken branch or jal/jalr
mem_rd  input  5  MEM destination
mem_reg_write  input  1  MEM writes rd
mem_req  input  1  MEM issues load/store this cycle
dmem_ready  input  1  data memory completes access
imem_ready  input  1  instruction fetch valid
wb_rd  input  5  WB destination
wb_reg_write  input  1  WB writes rd
stall_if  output  1  hold PC and IF/ID
stall_id  output  1  hold ID/EX
stall_ex  output  1  hold EX/MEM
stall_mem  output  1  hold MEM/WB
bubble_id  output  1  load NOP into IF/ID
bubble_ex  output  1  load NOP into ID/EX
pc_sel  output  2  0 PC+4, 1 EX target, 2 trap vector
fwd_a  output  2  EX operand A: 0 regfile, 1 from MEM, 2 from WB
fwd_b  output  2  EX operand B: same encoding
trap_req  output  1  one-cycle pulse to CSR unit
trap_cause  output  1  0 ecall, 1 ebreak (registered)
stall_cnt  output  CNT_W  cycles with stall_if asserted, saturating

Behaviour:
- Reset (rstn low, async):
  - state=RUN, drain counter=0, trap_cause=0, stall_cnt=0.
  - Outputs forced to: stalls 0, bubble_id=bubble_ex=1, pc_sel=0, trap_req=0.
- Forwarding (combinational, all states):
  - fwd_a=1 if mem_reg_write && mem_rd!=0 && mem_rd==id_rs1 && id_use_rs1.
  - Otherwise fwd_a=2 on the same compare against wb_*; otherwise 0.
  - MEM beats WB. fwd_b is identical using rs2.
  - rd=0 never forwards.
- dwait = mem_req && !dmem_ready.
- Load-use = ex_mem_read && ex_rd!=0 && ((ex_rd==id_rs1 && id_use_rs1) || (ex_rd==id_rs2 && id_use_rs2)).
- FSM states: RUN, MEM_WAIT, TRAP_DRAIN, TRAP_REDIRECT.
- RUN priority, highest first:
  1. dwait: all four stalls=1, go to MEM_WAIT. The stall is asserted in the same cycle dwait is detected.
  2. ex_redirect: pc_sel=1, bubble_id=1, bubble_ex=1. A younger trap or load-use in ID is discarded.
  3. id_syscall_op|id_break_op:
     - stall_if=1, bubble_ex=1.
     - Latch trap_cause; load counter DRAIN_CYCLES-1; go to TRAP_DRAIN.
  4. load-use: stall_if=1, bubble_ex=1 for exactly one cycle. Next cycle the load is in MEM and the consumer takes fwd=2 from WB one cycle later (normal path).
  5. !imem_ready: stall_if=1, bubble_id=1.
- MEM_WAIT:
  - All stalls=1 until dmem_ready.
  - On the dmem_ready cycle, stalls deassert (combinational) and the FSM returns to RUN. The pending RUN events are evaluated that same cycle.
- TRAP_DRAIN:
  - stall_if=1, bubble_ex=1.
  - Counter decrements each cycle without dwait; on dwait, all stalls=1 and the counter holds.
  - Counter==0 with no dwait: go to TRAP_REDIRECT.
- TRAP_REDIRECT (one cycle): trap_req=1, pc_sel=2, bubble_id=1, bubble_ex=1, then RUN.
- stall_cnt increments every cycle stall_if=1 and saturates at all-ones.
- Reset mid-drain or mid-wait returns immediately to RUN; no trap_req is emitted.

Test Plan:
- lw a5,0(a1) in EX (ex_rd=15, ex_mem_read=1), add a4,a5,a3 in ID (rs1=15) -> stall_if=1, bubble_ex=1 for 1 cycle; two cycles later fwd_a=2, fwd_b=0.
- add a4,a4,tp then sub a5,a4,a3 back-to-back (mem_rd=14, mem_reg_write=1, id_rs1=14) -> fwd_a=1, no stall; same case with mem_rd=0 -> fwd_a=0.
- beq a2,a5 taken (ex_redirect=1) while ID holds ecall -> pc_sel=1, bubble_id=bubble_ex=1, state stays RUN, trap_req never pulses.
- ecall in ID, no waits -> stall_if high 3 cycles, then trap_req=1 with pc_sel=2, trap_cause=0 for exactly 1 cycle; same with ebreak -> trap_cause=1.
- sw a2,64(a3) in MEM with dmem_ready low 4 cycles -> all stalls=1 for 4 cycles, released on the ready cycle; during TRAP_DRAIN the same wait extends the drain by 4 cycles.
- rstn pulsed low during TRAP_DRAIN -> no trap_req; stall_cnt=0; pc_sel=0 after release.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: forwarding selects, stall/bubble
// enables, PC source and the ecall/ebreak drain-then-redirect trap sequencer.
module pipeline_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             id_syscall_op_i,
  input  logic             id_break_op_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_redirect_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic             mem_req_i,
  input  logic             dmem_ready_i,
  input  logic             imem_ready_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_reg_write_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             bubble_id_o,
  output logic             bubble_ex_o,
  output logic [1:0]       pc_sel_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             trap_req_o,
  output logic             trap_cause_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StTrapDrain,
    StTrapRedirect
  } state_e;

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              cause_q, cause_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic dwait, load_use, run_eval;

  // A load always writes rd, so the load-use check keys off ex_mem_read alone.
  logic unused_ex_reg_write;
  assign unused_ex_reg_write = ex_reg_write_i;

  function automatic logic fwd_hit(logic [4:0] rd, logic we, logic [4:0] rs, logic use_rs);
    return we && (rd != 5'd0) && (rd == rs) && use_rs;
  endfunction

  always_comb begin
    fwd_a_o = 2'd0;
    if (fwd_hit(mem_rd_i, mem_reg_write_i, id_rs1_i, id_use_rs1_i)) begin
      fwd_a_o = 2'd1;
    end else if (fwd_hit(wb_rd_i, wb_reg_write_i, id_rs1_i, id_use_rs1_i)) begin
      fwd_a_o = 2'd2;
    end
    fwd_b_o = 2'd0;
    if (fwd_hit(mem_rd_i, mem_reg_write_i, id_rs2_i, id_use_rs2_i)) begin
      fwd_b_o = 2'd1;
    end else if (fwd_hit(wb_rd_i, wb_reg_write_i, id_rs2_i, id_use_rs2_i)) begin
      fwd_b_o = 2'd2;
    end
  end

  assign dwait    = mem_req_i && !dmem_ready_i;
  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    (((ex_rd_i == id_rs1_i) && id_use_rs1_i) ||
                     ((ex_rd_i == id_rs2_i) && id_use_rs2_i));

  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    bubble_id_o = 1'b0;
    bubble_ex_o = 1'b0;
    pc_sel_o    = 2'd0;
    trap_req_o  = 1'b0;
    state_d     = state_q;
    drain_d     = drain_q;
    cause_d     = cause_q;
    run_eval    = 1'b0;

    unique case (state_q)
      StRun: run_eval = 1'b1;
      StMemWait: begin
        if (dmem_ready_i) begin
          run_eval = 1'b1;
        end else begin
          {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o} = 4'b1111;
        end
      end
      StTrapDrain: begin
        stall_if_o  = 1'b1;
        bubble_ex_o = 1'b1;
        if (dwait) begin
          {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o} = 4'b1111;
        end else if (drain_q <= DrainW'(1)) begin
          // The detect cycle in RUN already retired one older instruction.
          drain_d = '0;
          state_d = StTrapRedirect;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
      StTrapRedirect: begin
        trap_req_o  = 1'b1;
        pc_sel_o    = 2'd2;
        bubble_id_o = 1'b1;
        bubble_ex_o = 1'b1;
        state_d     = StRun;
      end
      default: state_d = StRun;
    endcase

    if (run_eval) begin
      state_d = StRun;
      if (dwait) begin
        {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o} = 4'b1111;
        state_d = StMemWait;
      end else if (ex_redirect_i) begin
        pc_sel_o    = 2'd1;
        bubble_id_o = 1'b1;
        bubble_ex_o = 1'b1;
      end else if (id_syscall_op_i || id_break_op_i) begin
        stall_if_o  = 1'b1;
        bubble_ex_o = 1'b1;
        cause_d     = id_break_op_i;
        drain_d     = DrainW'(DRAIN_CYCLES - 1);
        state_d     = (DRAIN_CYCLES > 1) ? StTrapDrain : StTrapRedirect;
      end else if (load_use) begin
        stall_if_o  = 1'b1;
        bubble_ex_o = 1'b1;
      end else if (!imem_ready_i) begin
        stall_if_o  = 1'b1;
        bubble_id_o = 1'b1;
      end
    end

    if (!rstn_i) begin
      {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o} = 4'b0000;
      bubble_id_o = 1'b1;
      bubble_ex_o = 1'b1;
      pc_sel_o    = 2'd0;
      trap_req_o  = 1'b0;
    end
  end

  assign stall_cnt_d = (stall_if_o && (stall_cnt_q != {CNT_W{1'b1}})) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StRun;
      drain_q     <= '0;
      cause_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cause_q     <= cause_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign trap_cause_o = cause_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard/trap scenarios then randomized
// traffic, every cycle compared against a behavioural model of the controller.
module tb_pipeline_ctrl;

  localparam int unsigned Drain = 3;
  localparam int unsigned CntW  = 6;
  localparam int          CntMax = (1 << CntW) - 1;

  logic clk, rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, id_syscall_op, id_break_op;
  logic ex_reg_write, ex_mem_read, ex_redirect, mem_reg_write, mem_req;
  logic dmem_ready, imem_ready, wb_reg_write;
  logic stall_if, stall_id, stall_ex, stall_mem, bubble_id, bubble_ex, trap_req, trap_cause;
  logic [1:0] pc_sel, fwd_a, fwd_b;
  logic [CntW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit m_wait, m_draining, m_redir, m_cause;
  int m_drain_left, m_cnt;

  pipeline_ctrl #(.DRAIN_CYCLES(Drain), .CNT_W(CntW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1),
    .id_use_rs2_i(id_use_rs2), .id_syscall_op_i(id_syscall_op), .id_break_op_i(id_break_op),
    .ex_rd_i(ex_rd), .ex_reg_write_i(ex_reg_write), .ex_mem_read_i(ex_mem_read),
    .ex_redirect_i(ex_redirect), .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write),
    .mem_req_i(mem_req), .dmem_ready_i(dmem_ready), .imem_ready_i(imem_ready),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
    .stall_mem_o(stall_mem), .bubble_id_o(bubble_id), .bubble_ex_o(bubble_ex),
    .pc_sel_o(pc_sel), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .trap_req_o(trap_req),
    .trap_cause_o(trap_cause), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Newest older instruction that produces rs wins; x0 is never a producer.
  function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input logic use_rs);
    if (use_rs && rs != 0 && mem_reg_write && mem_rd == rs) return 2'd1;
    if (use_rs && rs != 0 && wb_reg_write && wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_draining = 0; m_redir = 0; m_cause = 0; m_drain_left = 0; m_cnt = 0;
  endtask

  task automatic step();
    logic [3:0] e_st;
    logic e_bid, e_bex, e_trap;
    logic [1:0] e_pc;
    bit dwait, lu;
    int old_cnt;
    bit old_cause;
    @(negedge clk);
    e_st = 4'b0; e_bid = 0; e_bex = 0; e_trap = 0; e_pc = 2'd0;
    old_cnt = m_cnt;
    old_cause = m_cause;
    dwait = mem_req && !dmem_ready;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    if (!rstn) begin
      e_bid = 1; e_bex = 1;
      model_reset();
      old_cnt = 0; old_cause = 0;
    end else if (m_redir) begin
      e_trap = 1; e_pc = 2'd2; e_bid = 1; e_bex = 1;
      m_redir = 0;
    end else if (m_draining) begin
      e_st[3] = 1; e_bex = 1;
      if (dwait) e_st = 4'b1111;
      else begin
        m_drain_left--;
        if (m_drain_left == 0) begin m_draining = 0; m_redir = 1; end
      end
    end else if (m_wait && !dmem_ready) begin
      e_st = 4'b1111;
    end else begin
      m_wait = 0;
      if (dwait) begin
        e_st = 4'b1111; m_wait = 1;
      end else if (ex_redirect) begin
        e_pc = 2'd1; e_bid = 1; e_bex = 1;
      end else if (id_syscall_op || id_break_op) begin
        e_st[3] = 1; e_bex = 1; m_cause = id_break_op;
        m_drain_left = Drain - 1;
        if (m_drain_left == 0) m_redir = 1; else m_draining = 1;
      end else if (lu) begin
        e_st[3] = 1; e_bex = 1;
      end else if (!imem_ready) begin
        e_st[3] = 1; e_bid = 1;
      end
    end
    if (rstn && e_st[3] && m_cnt < CntMax) m_cnt++;
    check_eq("stalls", {stall_if, stall_id, stall_ex, stall_mem}, e_st);
    check_eq("bubble_id", bubble_id, e_bid);
    check_eq("bubble_ex", bubble_ex, e_bex);
    check_eq("pc_sel", pc_sel, e_pc);
    check_eq("trap_req", trap_req, e_trap);
    check_eq("trap_cause", trap_cause, old_cause);
    check_eq("stall_cnt", stall_cnt, old_cnt);
    check_eq("fwd_a", fwd_a, exp_fwd(id_rs1, id_use_rs1));
    check_eq("fwd_b", fwd_b, exp_fwd(id_rs2, id_use_rs2));
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_syscall_op = 0; id_break_op = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_rd = 0; mem_reg_write = 0; mem_req = 0; dmem_ready = 1; imem_ready = 1;
    wb_rd = 0; wb_reg_write = 0;
  endtask

  task automatic rand_inputs();
    id_rs1 = 5'($urandom_range(0, 3));  id_rs2 = 5'($urandom_range(0, 3));
    id_use_rs1 = ($urandom_range(0, 99) < 80); id_use_rs2 = ($urandom_range(0, 99) < 60);
    id_syscall_op = ($urandom_range(0, 99) < 6); id_break_op = ($urandom_range(0, 99) < 4);
    ex_rd = 5'($urandom_range(0, 3)); ex_reg_write = ($urandom_range(0, 99) < 70);
    ex_mem_read = ($urandom_range(0, 99) < 40); ex_redirect = ($urandom_range(0, 99) < 10);
    mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = ($urandom_range(0, 99) < 70);
    mem_req = ($urandom_range(0, 99) < 30); dmem_ready = ($urandom_range(0, 99) < 50);
    imem_ready = ($urandom_range(0, 99) < 85);
    wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = ($urandom_range(0, 99) < 70);
  endtask

  task automatic idle_steps(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    set_idle();
    rstn = 0;
    step(); step();
    rstn = 1;
    idle_steps(2);

    // lw a5 in EX, add a4,a5,a3 in ID -> one load-use stall, then forwarding from MEM/WB
    ex_rd = 15; ex_mem_read = 1; ex_reg_write = 1;
    id_rs1 = 15; id_use_rs1 = 1; id_rs2 = 13; id_use_rs2 = 1;
    step();
    ex_rd = 0; ex_mem_read = 0; ex_reg_write = 0; mem_rd = 15; mem_reg_write = 1;
    step();
    mem_rd = 0; mem_reg_write = 0; wb_rd = 15; wb_reg_write = 1;
    step();

    // Back-to-back ALU dependency from MEM, and rd=0 never forwarding
    set_idle(); mem_rd = 14; mem_reg_write = 1; id_rs1 = 14; id_use_rs1 = 1; step();
    mem_rd = 0; id_rs1 = 0; step();

    // Taken branch in EX squashes ecall in ID
    set_idle(); ex_redirect = 1; id_syscall_op = 1; step();
    idle_steps(5);

    // ecall and ebreak with no waits
    set_idle(); id_syscall_op = 1; step();
    idle_steps(6);
    set_idle(); id_break_op = 1; step();
    idle_steps(6);

    // Store held 4 cycles by data memory
    set_idle(); mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) step();
    dmem_ready = 1; step();
    idle_steps(2);

    // Same wait landing inside the trap drain
    set_idle(); id_syscall_op = 1; step();
    set_idle(); mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) step();
    dmem_ready = 1;
    for (int i = 0; i < 6; i++) step();
    idle_steps(2);

    // Reset pulsed mid-drain
    set_idle(); id_syscall_op = 1; step();
    set_idle(); step();
    rstn = 0; step();
    rstn = 1; idle_steps(5);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rstn = ($urandom_range(0, 199) != 0);
      step();
    end
    rstn = 1;
    idle_steps(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
